// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the IF-stage fetch unit.
// The bubble encoding is all zeros so it matches the IF/ID flush value.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC      = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// IF-stage front end: owns the PC and keeps at most one instruction-memory
// request outstanding. It parks the response in a 1-entry buffer that feeds the
// IF/ID register.
// Decode stalls and execute-stage redirects are absorbed here. A response that
// belongs to a superseded PC is dropped through drop_q.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (sticky misaligned-redirect
// flag that parks fetch; when undefined, redirect targets are word-aligned).
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] INST_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC4_F,
  output logic        fetch_bubble
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  req_addr_q;
  logic         buf_valid;
  logic [31:0]  buf_inst;
  logic [31:0]  buf_pc;
  logic         drop_q;

  logic         issue;
  logic         fill;
  logic         set_drop;
  logic         clr_drop;
  logic         park;
  logic [31:0]  redir_pc_eff;

`ifdef FETCH_MISALIGN_CHK_EN
  logic         misaligned_q;
`endif

  // Next-state decode, handshake bookkeeping and register-sourced outputs.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    fill     = 1'b0;
    set_drop = 1'b0;
    clr_drop = 1'b0;

`ifdef FETCH_MISALIGN_CHK_EN
    park             = misaligned_q;
    redir_pc_eff     = redirect_pc;
    fetch_misaligned = misaligned_q;
`else
    park             = 1'b0;
    redir_pc_eff     = redirect_pc & ~32'h0000_0003;
`endif

    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && (!buf_valid || !stall) && !park) begin
          issue   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
        if (redirect_valid) begin
          set_drop = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_IDLE;
          if (!drop_q && !redirect_valid) begin
            fill = 1'b1;
          end else begin
            clr_drop = 1'b1;
          end
        end else if (redirect_valid) begin
          set_drop = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = req_addr_q;
    fetch_bubble   = !buf_valid;
    INST_F         = buf_valid ? buf_inst          : BUBBLE_INST;
    PC_F           = buf_valid ? buf_pc            : 32'h0;
    PC4_F          = buf_valid ? (buf_pc + PC_INC) : 32'h0;
  end

  // State, PC, request address, holding buffer and drop flag; redirect is applied last so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_valid  <= 1'b0;
      buf_inst   <= BUBBLE_INST;
      buf_pc     <= 32'h0;
      drop_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;

      if (issue) begin
        req_addr_q <= pc_q;
      end

      if (set_drop) begin
        drop_q <= 1'b1;
      end else if (clr_drop) begin
        drop_q <= 1'b0;
      end

      if (buf_valid && !stall) begin
        buf_valid <= 1'b0;
      end

      if (fill) begin
        buf_valid <= 1'b1;
        buf_inst  <= imem_rsp_data;
        buf_pc    <= req_addr_q;
        pc_q      <= req_addr_q + PC_INC;
      end

      if (redirect_valid) begin
        pc_q      <= redir_pc_eff;
        buf_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        misaligned_q <= |redirect_pc[1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, basic fetch, stall hold,
// redirects in each FSM state, ready back-pressure, alignment handling and PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] INST_F;
  logic [31:0] PC_F;
  logic [31:0] PC4_F;
  logic        fetch_bubble;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misaligned;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .INST_F           (INST_F),
    .PC_F             (PC_F),
    .PC4_F            (PC4_F),
    .fetch_bubble     (fetch_bubble)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic rspv, input logic [31:0] rspd);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = rspd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    checkOutput("rst_inst", INST_F, 32'h0);
    checkOutput("rst_pc", PC_F, 32'h0);
    checkOutput("rst_pc4", PC4_F, 32'h0);
    checkOutput("rst_bubble", {31'h0, fetch_bubble}, 32'h1);
    rst = 1'b0;

    // Basic fetch at reset PC with one-cycle response
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t1_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t1_req_addr", imem_req_addr, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t1_wait_req_valid", {31'h0, imem_req_valid}, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0050_0093);
    checkOutput("t1_inst", INST_F, 32'h0050_0093);
    checkOutput("t1_pc", PC_F, 32'h0);
    checkOutput("t1_pc4", PC4_F, 32'h4);
    checkOutput("t1_bubble", {31'h0, fetch_bubble}, 32'h0);

    // Stall for five cycles with the buffer full
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
      checkOutput("t2_hold_inst", INST_F, 32'h0050_0093);
      checkOutput("t2_no_req", {31'h0, imem_req_valid}, 32'h0);
    end
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t2_release_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t2_release_req_addr", imem_req_addr, 32'h4);
    checkOutput("t2_release_bubble", {31'h0, fetch_bubble}, 32'h1);

    // Redirect while waiting for a response
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 1, 32'h100, 1, 0, 32'h0);
    checkOutput("t3_redir_bubble", {31'h0, fetch_bubble}, 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
    checkOutput("t3_drop_bubble", {31'h0, fetch_bubble}, 32'h1);
    checkOutput("t3_drop_inst", INST_F, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t3_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t3_req_addr", imem_req_addr, 32'h100);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h1111_1111);
    checkOutput("t3_inst", INST_F, 32'h1111_1111);
    checkOutput("t3_pc", PC_F, 32'h100);
    checkOutput("t3_pc4", PC4_F, 32'h104);

    // Redirect in the same cycle as the response
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t4a_req_addr", imem_req_addr, 32'h104);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 1, 32'h100, 1, 1, 32'h2222_2222);
    checkOutput("t4a_bubble", {31'h0, fetch_bubble}, 32'h1);
    checkOutput("t4a_inst", INST_F, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t4a_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t4a_req_addr2", imem_req_addr, 32'h100);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h3333_3333);
    checkOutput("t4a_inst2", INST_F, 32'h3333_3333);

    // Redirect under stall with the buffer full
    applyStimulus(1, 1, 32'h100, 1, 0, 32'h0);
    checkOutput("t4b_bubble", {31'h0, fetch_bubble}, 32'h1);
    checkOutput("t4b_pc", PC_F, 32'h0);
    checkOutput("t4b_no_req", {31'h0, imem_req_valid}, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t4b_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t4b_req_addr", imem_req_addr, 32'h100);

    // Back-pressure on ready with a redirect in the middle
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t5_hold1_addr", imem_req_addr, 32'h100);
    applyStimulus(0, 1, 32'h200, 0, 0, 32'h0);
    checkOutput("t5_hold2_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t5_hold2_addr", imem_req_addr, 32'h100);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t5_hold3_addr", imem_req_addr, 32'h100);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t5_accepted", {31'h0, imem_req_valid}, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h4444_4444);
    checkOutput("t5_drop_bubble", {31'h0, fetch_bubble}, 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t5_req_addr", imem_req_addr, 32'h200);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h5555_5555);
    checkOutput("t5_inst", INST_F, 32'h5555_5555);
    checkOutput("t5_pc", PC_F, 32'h200);

`ifndef FETCH_MISALIGN_CHK_EN
    // Low address bits of a redirect target are ignored
    applyStimulus(0, 1, 32'h302, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("align_req_addr", imem_req_addr, 32'h300);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h6666_6666);
    checkOutput("align_pc", PC_F, 32'h300);
`endif

    // PC wraps from the top of the address space
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h7777_7777);
    checkOutput("wrap_pc", PC_F, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", PC4_F, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("wrap_next_addr", imem_req_addr, 32'h0);
    checkOutput("wrap_next_valid", {31'h0, imem_req_valid}, 32'h1);

`ifdef FETCH_MISALIGN_CHK_EN
    // Misaligned redirect parks fetch until an aligned redirect arrives
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h8888_8888);
    checkOutput("mis_fill_inst", INST_F, 32'h8888_8888);
    applyStimulus(0, 1, 32'h102, 1, 0, 32'h0);
    checkOutput("mis_flag_set", {31'h0, fetch_misaligned}, 32'h1);
    checkOutput("mis_bubble", {31'h0, fetch_bubble}, 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("mis_no_req1", {31'h0, imem_req_valid}, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("mis_no_req2", {31'h0, imem_req_valid}, 32'h0);
    applyStimulus(0, 1, 32'h200, 1, 0, 32'h0);
    checkOutput("mis_flag_clr", {31'h0, fetch_misaligned}, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("mis_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("mis_req_addr", imem_req_addr, 32'h200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
